// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_if
//  Description : Bundle of decode-side inputs, writeback candidates used for
//                operand forwarding, and the EX-side outputs of id_ex_stage.
//                master : upstream pipeline / testbench (drives id_*, flush,
//                         mem_*, wb_*; observes stall and ex_*)
//                slave  : id_ex_stage
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_if #(
    parameter int WIDTH = 32
);
    // Decode (ID) side
    logic             id_valid;
    logic [WIDTH-1:0] id_rs_val;
    logic [WIDTH-1:0] id_rt_val;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [WIDTH-1:0] id_imm;
    logic [4:0]       id_shamt;
    logic [5:0]       id_funct;
    logic [2:0]       id_alu_op;
    logic [6:0]       id_ctrl;      // {regWrite, memToReg, memRead, memWrite, branch, aluSrc, regDst}
    logic             flush;

    // Writeback candidates from EX/MEM and MEM/WB
    logic             mem_reg_write;
    logic [4:0]       mem_rd;
    logic [WIDTH-1:0] mem_result;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_result;

    // EX side
    logic             stall;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_in1;
    logic [WIDTH-1:0] ex_in2;
    logic [WIDTH-1:0] ex_store_data;
    logic [5:0]       ex_funct;
    logic [2:0]       ex_alu_op;
    logic [4:0]       ex_shamt;
    logic [4:0]       ex_dest;
    logic [6:0]       ex_ctrl;

    modport master (
        output id_valid, id_rs_val, id_rt_val, id_rs, id_rt, id_rd, id_imm,
               id_shamt, id_funct, id_alu_op, id_ctrl, flush,
               mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result,
        input  stall, ex_valid, ex_in1, ex_in2, ex_store_data,
               ex_funct, ex_alu_op, ex_shamt, ex_dest, ex_ctrl
    );

    modport slave (
        input  id_valid, id_rs_val, id_rt_val, id_rs, id_rt, id_rd, id_imm,
               id_shamt, id_funct, id_alu_op, id_ctrl, flush,
               mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result,
        output stall, ex_valid, ex_in1, ex_in2, ex_store_data,
               ex_funct, ex_alu_op, ex_shamt, ex_dest, ex_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register for the pipelined MIPS core.
//                Registers the decoded instruction, forwards the youngest
//                writeback value into the ALU operands, and detects load-use
//                hazards (stall + bubble insertion).
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - id_ex_if.slave (decode inputs, flush, EX/MEM and
//                       MEM/WB writeback candidates, stall, ex_* outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    id_ex_if.slave    bus
);

    // Control-bit positions within {regWrite, memToReg, memRead, memWrite,
    // branch, aluSrc, regDst}
    localparam int c_CTRL_MEMREAD = 4;
    localparam int c_CTRL_ALUSRC  = 1;
    localparam int c_CTRL_REGDST  = 0;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [WIDTH-1:0] r_rs_val;
    logic [WIDTH-1:0] r_rt_val;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_rd;
    logic [WIDTH-1:0] r_imm;
    logic [4:0]       r_shamt;
    logic [5:0]       r_funct;
    logic [2:0]       r_alu_op;
    logic [6:0]       r_ctrl;

    logic [4:0]       w_dest;
    logic             w_stall;
    logic             w_bubble;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;

    // Destination of the instruction currently in EX. A bubble has
    // ctrl=0 and rt=0, so its destination is $0 and it never matches.
    assign w_dest = r_ctrl[c_CTRL_REGDST] ? r_rd : r_rt;

    // Load-use hazard: the load in EX cannot supply its data until it
    // reaches MEM/WB, so the dependent instruction in decode waits a cycle.
    assign w_stall = bus.id_valid & r_valid & r_ctrl[c_CTRL_MEMREAD]
                   & (w_dest != 5'd0)
                   & ((w_dest == bus.id_rs) | (w_dest == bus.id_rt));

    assign w_bubble = bus.flush | w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_rs_val <= '0;
            r_rt_val <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_shamt  <= '0;
            r_funct  <= '0;
            r_alu_op <= '0;
            r_ctrl   <= '0;
        end else if (w_bubble) begin
            // Fully cleared bubble: no write, no memory access, dest $0.
            r_valid  <= 1'b0;
            r_rs_val <= '0;
            r_rt_val <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_shamt  <= '0;
            r_funct  <= '0;
            r_alu_op <= '0;
            r_ctrl   <= '0;
        end else begin
            // id_valid=0 still loads the fields; consumers qualify on valid.
            r_valid  <= bus.id_valid;
            r_rs_val <= bus.id_rs_val;
            r_rt_val <= bus.id_rt_val;
            r_rs     <= bus.id_rs;
            r_rt     <= bus.id_rt;
            r_rd     <= bus.id_rd;
            r_imm    <= bus.id_imm;
            r_shamt  <= bus.id_shamt;
            r_funct  <= bus.id_funct;
            r_alu_op <= bus.id_alu_op;
            r_ctrl   <= bus.id_ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding. EX/MEM is checked first because it holds the
    // younger result; $0 is hard-wired and never forwarded.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_forward(
        input logic [4:0]       src,
        input logic [WIDTH-1:0] reg_val,
        input logic             mem_we,
        input logic [4:0]       mem_rd,
        input logic [WIDTH-1:0] mem_res,
        input logic             wb_we,
        input logic [4:0]       wb_rd,
        input logic [WIDTH-1:0] wb_res
    );
        logic [WIDTH-1:0] val;
        val = reg_val;
        if (src != 5'd0) begin
            if (mem_we && (mem_rd == src)) begin
                val = mem_res;
            end else if (wb_we && (wb_rd == src)) begin
                val = wb_res;
            end
        end
        return val;
    endfunction

    always_comb begin
        w_fwd_rs = f_forward(r_rs, r_rs_val,
                             bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                             bus.wb_reg_write, bus.wb_rd, bus.wb_result);
        w_fwd_rt = f_forward(r_rt, r_rt_val,
                             bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                             bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall         = w_stall;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_in1        = w_fwd_rs;
    assign bus.ex_in2        = r_ctrl[c_CTRL_ALUSRC] ? r_imm : w_fwd_rt;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_funct      = r_funct;
    assign bus.ex_alu_op     = r_alu_op;
    assign bus.ex_shamt      = r_shamt;
    assign bus.ex_dest       = w_dest;
    assign bus.ex_ctrl       = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Directed testbench for id_ex_stage. Stimulus pushes the
//                hand-computed expected EX-side view for a given cycle into a
//                queue; a monitor samples on the falling edge and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int WIDTH = 32;

    localparam logic [6:0] c_CTRL_ADD  = 7'b1000001;  // regWrite, regDst
    localparam logic [6:0] c_CTRL_LW   = 7'b1110010;  // regWrite, memToReg, memRead, aluSrc
    localparam logic [6:0] c_CTRL_ADDI = 7'b1000010;  // regWrite, aluSrc
    localparam logic [5:0] c_F_ADD     = 6'h20;
    localparam logic [2:0] c_OP_R      = 3'b010;
    localparam logic [2:0] c_OP_MEM    = 3'b000;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   done;

    id_ex_if #(.WIDTH(WIDTH)) bus ();

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string            name;
        int               cyc;
        logic             valid;
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic [WIDTH-1:0] st;
        logic [4:0]       dest;
        logic [6:0]       ctrl;
        logic [5:0]       funct;
        logic [2:0]       aop;
        logic [4:0]       sh;
        logic             stall;
    } exp_t;

    exp_t sb[$];

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [WIDTH-1:0] rsv, input logic [WIDTH-1:0] rtv,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [WIDTH-1:0] imm, input logic [5:0] funct,
                            input logic [2:0] aop, input logic [6:0] ctrl);
        bus.id_valid  = v;
        bus.id_rs_val = rsv;
        bus.id_rt_val = rtv;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rd     = rd;
        bus.id_imm    = imm;
        bus.id_shamt  = 5'd0;
        bus.id_funct  = funct;
        bus.id_alu_op = aop;
        bus.id_ctrl   = ctrl;
    endtask

    task automatic drive_fwd(input logic mw, input logic [4:0] mrd, input logic [WIDTH-1:0] mres,
                             input logic ww, input logic [4:0] wrd, input logic [WIDTH-1:0] wres);
        bus.mem_reg_write = mw;
        bus.mem_rd        = mrd;
        bus.mem_result    = mres;
        bus.wb_reg_write  = ww;
        bus.wb_rd         = wrd;
        bus.wb_result     = wres;
    endtask

    task automatic expect_ex(input string name, input logic v,
                             input logic [WIDTH-1:0] in1, input logic [WIDTH-1:0] in2,
                             input logic [WIDTH-1:0] st, input logic [4:0] dest,
                             input logic [6:0] ctrl, input logic [5:0] funct,
                             input logic [2:0] aop, input logic stall);
        exp_t e;
        e.name  = name;
        e.cyc   = cyc;
        e.valid = v;
        e.in1   = in1;
        e.in2   = in2;
        e.st    = st;
        e.dest  = dest;
        e.ctrl  = ctrl;
        e.funct = funct;
        e.aop   = aop;
        e.sh    = 5'd0;
        e.stall = stall;
        sb.push_back(e);
    endtask

    task automatic expect_zero(input string name);
        expect_ex(name, 1'b0, '0, '0, '0, 5'd0, 7'd0, 6'd0, 3'd0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    task automatic chk(input string name, input string field,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                chk(e.name, "ex_valid",      WIDTH'(bus.ex_valid),  WIDTH'(e.valid));
                chk(e.name, "ex_in1",        bus.ex_in1,            e.in1);
                chk(e.name, "ex_in2",        bus.ex_in2,            e.in2);
                chk(e.name, "ex_store_data", bus.ex_store_data,     e.st);
                chk(e.name, "ex_dest",       WIDTH'(bus.ex_dest),   WIDTH'(e.dest));
                chk(e.name, "ex_ctrl",       WIDTH'(bus.ex_ctrl),   WIDTH'(e.ctrl));
                chk(e.name, "ex_funct",      WIDTH'(bus.ex_funct),  WIDTH'(e.funct));
                chk(e.name, "ex_alu_op",     WIDTH'(bus.ex_alu_op), WIDTH'(e.aop));
                chk(e.name, "ex_shamt",      WIDTH'(bus.ex_shamt),  WIDTH'(e.sh));
                chk(e.name, "stall",         WIDTH'(bus.stall),     WIDTH'(e.stall));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        done  = 1'b0;
        rst   = 1'b1;
        bus.flush = 1'b0;
        drive_id(1'b0, '0, '0, 5'd0, 5'd0, 5'd0, '0, 6'd0, 3'd0, 7'd0);
        drive_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

        // cycle 1: reset state
        next_cycle();
        expect_zero("reset");

        // cycle 2: release reset, decode add $3,$1,$2
        next_cycle();
        rst = 1'b0;
        expect_zero("reset_hold");
        drive_id(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);

        // cycle 3: add in EX, no forwarding; decode repeats the add
        next_cycle();
        expect_ex("add_plain", 1'b1, 32'd5, 32'd7, 32'd7, 5'd3, c_CTRL_ADD, c_F_ADD, c_OP_R, 1'b0);

        // cycle 4: both pipes write $1 -> EX/MEM wins
        next_cycle();
        drive_fwd(1'b1, 5'd1, 32'd20, 1'b1, 5'd1, 32'd9);
        expect_ex("fwd_mem_prio", 1'b1, 32'd20, 32'd7, 32'd7, 5'd3, c_CTRL_ADD, c_F_ADD, c_OP_R, 1'b0);

        // cycle 5: EX/MEM not writing -> MEM/WB value; decode lw $4,0($7)
        next_cycle();
        drive_fwd(1'b0, 5'd1, 32'd20, 1'b1, 5'd1, 32'd9);
        expect_ex("fwd_wb", 1'b1, 32'd9, 32'd7, 32'd7, 5'd3, c_CTRL_ADD, c_F_ADD, c_OP_R, 1'b0);
        drive_id(1'b1, 32'd100, 32'd0, 5'd7, 5'd4, 5'd0, '0, 6'd0, c_OP_MEM, c_CTRL_LW);

        // cycle 6: lw in EX, decode add $5,$4,$6 -> load-use stall
        next_cycle();
        drive_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        drive_id(1'b1, 32'd111, 32'd6, 5'd4, 5'd6, 5'd5, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);
        expect_ex("lw_stall", 1'b1, 32'd100, 32'd0, 32'd0, 5'd4, c_CTRL_LW, 6'd0, c_OP_MEM, 1'b1);

        // cycle 7: bubble in EX, stall released
        next_cycle();
        expect_zero("bubble");

        // cycle 8: add in EX, load data arrives via MEM/WB; decode addi $8,$9,-4
        next_cycle();
        drive_fwd(1'b0, 5'd0, '0, 1'b1, 5'd4, 32'd55);
        expect_ex("after_stall", 1'b1, 32'd55, 32'd6, 32'd6, 5'd5, c_CTRL_ADD, c_F_ADD, c_OP_R, 1'b0);
        drive_id(1'b1, 32'd3, 32'd1, 5'd9, 5'd8, 5'd0, 32'hFFFF_FFFC, 6'd0, c_OP_MEM, c_CTRL_ADDI);

        // cycle 9: addi in EX, rt forwarded to 8; decode add $10,$0,$2
        next_cycle();
        drive_fwd(1'b1, 5'd8, 32'd8, 1'b0, 5'd0, '0);
        expect_ex("addi_imm", 1'b1, 32'd3, 32'hFFFF_FFFC, 32'd8, 5'd8, c_CTRL_ADDI, 6'd0, c_OP_MEM, 1'b0);
        drive_id(1'b1, 32'd0, 32'd7, 5'd0, 5'd2, 5'd10, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);

        // cycle 10: writes to $0 must not forward; decode add with flush
        next_cycle();
        drive_fwd(1'b1, 5'd0, 32'd99, 1'b1, 5'd0, 32'd77);
        expect_ex("no_fwd_r0", 1'b1, 32'd0, 32'd7, 32'd7, 5'd10, c_CTRL_ADD, c_F_ADD, c_OP_R, 1'b0);
        drive_id(1'b1, 32'd1, 32'd2, 5'd1, 5'd2, 5'd11, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);
        bus.flush = 1'b1;

        // cycle 11: flushed slot; decode lw $4,0($7)
        next_cycle();
        bus.flush = 1'b0;
        drive_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        expect_zero("flush");
        drive_id(1'b1, 32'd100, 32'd0, 5'd7, 5'd4, 5'd0, '0, 6'd0, c_OP_MEM, c_CTRL_LW);

        // cycle 12: stall, then reset during the stall
        next_cycle();
        drive_id(1'b1, 32'd111, 32'd6, 5'd4, 5'd6, 5'd5, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);
        expect_ex("lw_stall2", 1'b1, 32'd100, 32'd0, 32'd0, 5'd4, c_CTRL_LW, 6'd0, c_OP_MEM, 1'b1);
        rst = 1'b1;

        // cycle 13: everything cleared; decode an invalid add $3,$1,$2
        next_cycle();
        rst = 1'b0;
        expect_zero("rst_in_stall");
        drive_id(1'b0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);

        // cycle 14: invalid slot still carries its fields; decode lw $4
        next_cycle();
        expect_ex("invalid_loaded", 1'b0, 32'd5, 32'd7, 32'd7, 5'd3, c_CTRL_ADD, c_F_ADD, c_OP_R, 1'b0);
        drive_id(1'b1, 32'd100, 32'd0, 5'd7, 5'd4, 5'd0, '0, 6'd0, c_OP_MEM, c_CTRL_LW);

        // cycle 15: load-use hazard together with flush -> stall stays high
        next_cycle();
        drive_id(1'b1, 32'd111, 32'd6, 5'd4, 5'd6, 5'd5, '0, c_F_ADD, c_OP_R, c_CTRL_ADD);
        bus.flush = 1'b1;
        expect_ex("flush_stall", 1'b1, 32'd100, 32'd0, 32'd0, 5'd4, c_CTRL_LW, 6'd0, c_OP_MEM, 1'b1);

        // cycle 16: bubble
        next_cycle();
        bus.flush = 1'b0;
        expect_zero("flush_stall_bubble");

        next_cycle();
        next_cycle();
        done = 1'b1;
    end

    // Final report, also reached if the sequence never completes.
    initial begin
        fork
            wait (done);
            #2000;
        join_any
        disable fork;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: sequence incomplete at cycle %0d, expected completion", cyc);
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never sampled, expected at cycle %0d", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the extended ALU in the pipelined MIPS core. It registers the decoded instruction (register values, immediate, shamt, funct, aluOp, control bits) on each clock. In EX it drives forwarded operands `ex_in1` and `ex_in2` straight into the ALU. It also detects load-use hazards, and on a hazard stalls the front end and inserts a bubble.

## Interface
Parameters:
- `WIDTH`, 32, datapath width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode holds a real instruction
- `id_rs_val`, `id_rt_val`  in  WIDTH  register-file read data
- `id_rs`, `id_rt`, `id_rd`  in  5  register numbers
- `id_imm`  in  WIDTH  sign-extended immediate
- `id_shamt`  in  5  shift amount
- `id_funct`  in  6  funct field
- `id_alu_op`  in  3  aluOp from the control unit
- `id_ctrl`  in  7  {regWrite, memToReg, memRead, memWrite, branch, aluSrc, regDst}
- `flush`  in  1  kill the instruction entering EX (taken branch)
- `mem_reg_write`, `mem_rd`, `mem_result`  in  1/5/WIDTH  EX/MEM writeback candidate
- `wb_reg_write`, `wb_rd`, `wb_result`  in  1/5/WIDTH  MEM/WB writeback candidate
- `stall`  out  1  hold PC and IF/ID (combinational)
- `ex_valid`  out  1  EX holds a real instruction
- `ex_in1`, `ex_in2`  out  WIDTH  ALU operands (forwarded)
- `ex_store_data`  out  WIDTH  forwarded rt value, used by sw
- `ex_funct`, `ex_alu_op`, `ex_shamt`  out  6/3/5  registered ALU control fields
- `ex_dest`  out  5  destination register
- `ex_ctrl`  out  7  registered control bits

## Operation
- Registered state: valid, rs_val, rt_val, rs, rt, rd, imm, shamt, funct, alu_op, ctrl.
- Load-use hazard: `stall` = `id_valid` & `ex_valid` & `ex_ctrl`[memRead] & (`ex_dest` != 0) & (`ex_dest` == `id_rs` | `ex_dest` == `id_rt`).
- Each clock, in priority order:
  - `rst`: every register cleared to 0.
  - `flush` or `stall`: bubble. valid=0 and all fields cleared to 0, so `ex_ctrl`=0 and nothing is written.
  - Otherwise: load all `id_*` inputs, with valid=`id_valid`.
- Forwarding is combinational from registered state, evaluated separately for rs and rt:
  - If `mem_reg_write` and `mem_rd` == reg and reg != 0, use `mem_result`.
  - Else if `wb_reg_write` and `wb_rd` == reg and reg != 0, use `wb_result`.
  - Else use the registered value.
  - When EX/MEM and MEM/WB both match, EX/MEM wins (it holds the younger result).
- `ex_in1` = forwarded rs.
- `ex_in2` = `ex_ctrl`[aluSrc] ? imm : forwarded rt.
- `ex_store_data` = forwarded rt.
- `ex_dest` = `ex_ctrl`[regDst] ? rd : rt. Bubbles therefore give dest 0.
- Register $0 is never forwarded. A write to $0 upstream has no effect on operands.
- A hazard with a producer three instructions ahead is resolved by the register file (write-first). It is outside this block.

## Timing
- Latency: 1 cycle from `id_*` to the `ex_*` registered fields. `ex_in1`, `ex_in2` and `ex_store_data` are valid in that same cycle, after forwarding mux delay.
- Reset values: all `ex_*` outputs 0, `ex_valid`=0. `stall`=0, because `ex_valid`=0.
- Stall lasts exactly 1 cycle per load-use hazard. The cycle after the bubble, EX holds the bubble (memRead=0), so `stall` drops and the held instruction enters. The load's result then reaches it through the MEM/WB path.
- `flush` together with `stall`: bubble inserted and `stall` still asserted. Front-end precedence is owned by the hazard/PC logic.
- `rst` asserted mid-stream: the next edge clears everything. Any in-flight instruction is discarded and there is no partial state.
- `id_valid`=0 without a stall: a bubble propagates with its fields loaded. Consumers must qualify on `ex_valid`/`ex_ctrl`.

## Test plan
- Reset, then issue add $3,$1,$2 with rs_val=5, rt_val=7 and no forwarding -> next cycle `ex_in1`=5, `ex_in2`=7, `ex_dest`=3, `ex_valid`=1.
- EX in the add $3 and `mem_rd`=1, `mem_result`=20, `wb_rd`=1, `wb_result`=9 -> `ex_in1`=20 (EX/MEM priority). With `mem_reg_write`=0 -> `ex_in1`=9.
- lw $4 in EX; decode holds add $5,$4,$6 -> `stall`=1 for one cycle. Next cycle `ex_valid`=0 and `ex_ctrl`=0. The cycle after that, the add is in EX with `stall`=0.
- `mem_rd`=0, `mem_reg_write`=1, `mem_result`=99, EX rs=0 -> `ex_in1` = registered value, not 99.
- addi with aluSrc=1, imm=0xFFFFFFFC, rt forwarded to 8 -> `ex_in2`=0xFFFFFFFC and `ex_store_data`=8.
- `flush` asserted with a valid decode -> next cycle `ex_valid`=0 and all `ex_*` fields 0. Assert `rst` during a stall -> all outputs 0 and `stall`=0 on the next cycle.
